// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps all input vectors into a block under test and checks each 1-bit response against a latched truth table
module truth_table_checker #(
  parameter int IN_W   = 3,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**IN_W-1:0]   expected,
  output logic [IN_W-1:0]      dut_in,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic                 first_fail_valid,
  output logic [IN_W-1:0]      first_fail_vec
);
  localparam int CW = $clog2(SETTLE + 1);
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2**IN_W-1:0] exp_q;
  logic mismatch, sat, last;
  always_comb begin
    mismatch = dut_out != exp_q[dut_in];
    sat      = &err_count;
    last     = &dut_in;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      exp_q            <= '0;
      dut_in           <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE:
          if (start) begin
            state            <= ST_SETTLE;
            exp_q            <= expected;
            cnt              <= '0;
            dut_in           <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
          end
        ST_SETTLE: begin
          cnt   <= cnt + 1'b1;
          state <= (cnt == CW'(SETTLE - 1)) ? ST_SAMPLE : ST_SETTLE;
        end
        default: begin
          if (mismatch && !sat) err_count <= err_count + 1'b1;
          if (mismatch && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_vec   <= dut_in;
          end
          if (last) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
          end else begin
            state  <= ST_SETTLE;
            dut_in <= dut_in + 1'b1;
            cnt    <= '0;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: directed sweeps of three checker instances against small mock blocks
module tb_truth_table_checker;
  logic clk = 0, rst_n = 0;
  logic [2:0] st = '0;
  logic [7:0] expected = 8'hE8, exp1 = 8'hFF;
  logic [2:0] in0, in1, in2, ffv_vec0, ffv_vec1, ffv_vec2;
  logic [2:0] bz, dn, ps, ffv;
  logic [3:0] err0;
  logic [1:0] err1;
  logic [3:0] err2;
  logic o0, o1, o2;
  logic [1:0] p0 = '0, p2 = '0;
  int m0 = 0, m1 = 2, m2 = 3;
  int checks = 0, failures = 0;
  int cyc;

  always #5 clk = ~clk;

  function automatic logic mock(input int m, input logic [2:0] v);
    logic mj;
    mj = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    return m == 0 ? mj : m == 1 ? (mj && v != 3'd5) : 1'b0;
  endfunction

  // two-cycle registered-latency majority mocks
  always @(posedge clk) begin
    p0 <= {p0[0], mock(0, in0)};
    p2 <= {p2[0], mock(0, in2)};
  end
  always_comb begin
    o0 = m0 == 3 ? p0[1] : mock(m0, in0);
    o1 = mock(m1, in1);
    o2 = m2 == 3 ? p2[1] : mock(m2, in2);
  end

  truth_table_checker u0 (.clk(clk), .rst_n(rst_n), .start(st[0]), .expected(expected),
    .dut_in(in0), .dut_out(o0), .busy(bz[0]), .done(dn[0]), .pass(ps[0]),
    .err_count(err0), .first_fail_valid(ffv[0]), .first_fail_vec(ffv_vec0));
  truth_table_checker #(.ERR_W(2)) u1 (.clk(clk), .rst_n(rst_n), .start(st[1]), .expected(exp1),
    .dut_in(in1), .dut_out(o1), .busy(bz[1]), .done(dn[1]), .pass(ps[1]),
    .err_count(err1), .first_fail_valid(ffv[1]), .first_fail_vec(ffv_vec1));
  truth_table_checker #(.SETTLE(1)) u2 (.clk(clk), .rst_n(rst_n), .start(st[2]), .expected(expected),
    .dut_in(in2), .dut_out(o2), .busy(bz[2]), .done(dn[2]), .pass(ps[2]),
    .err_count(err2), .first_fail_valid(ffv[2]), .first_fail_vec(ffv_vec2));

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic pulse(input int i);
    @(negedge clk) st[i] = 1'b1;
    @(posedge clk);
    #1 st[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, inout int c);
    while (!dn[i] && c < 200) begin
      @(posedge clk);
      #1 c++;
    end
  endtask

  task automatic run(input int i, output int c);
    pulse(i);
    c = 0;
    wait_done(i, c);
  endtask

  initial begin
    #12;
    chk("rst_busy", bz[0], 0);
    chk("rst_done", dn[0], 0);
    chk("rst_dut_in", in0, 0);
    chk("rst_err", err0, 0);
    chk("rst_pass", ps[0], 0);
    chk("rst_ffv", ffv[0], 0);
    @(negedge clk) rst_n = 1'b1;

    // T1: majority, expected changed mid-run must not matter
    pulse(0);
    cyc = 0;
    repeat (5) begin @(posedge clk); #1 cyc++; end
    expected = 8'h00;
    wait_done(0, cyc);
    chk("t1_cycles", cyc, 24);
    chk("t1_pass", ps[0], 1);
    chk("t1_err", err0, 0);
    chk("t1_ffv", ffv[0], 0);
    chk("t1_busy", bz[0], 0);
    chk("t1_dut_in_hold", in0, 7);
    expected = 8'hE8;

    // T2: vector 5 forced low
    m0 = 1;
    run(0, cyc);
    chk("t2_err", err0, 1);
    chk("t2_ffv", ffv[0], 1);
    chk("t2_ffvec", ffv_vec0, 5);
    chk("t2_pass", ps[0], 0);

    // T3: constant-0 vs all-ones, 2-bit saturating count
    run(1, cyc);
    chk("t3_cycles", cyc, 24);
    chk("t3_err_sat", err1, 3);
    chk("t3_ffvec", ffv_vec1, 0);
    chk("t3_pass", ps[1], 0);

    // T4: restart from DONE clears, start mid-run ignored
    m0 = 0;
    pulse(0);
    chk("t4_clr_err", err0, 0);
    chk("t4_clr_ffv", ffv[0], 0);
    chk("t4_clr_done", dn[0], 0);
    chk("t4_busy", bz[0], 1);
    cyc = 0;
    repeat (9) begin @(posedge clk); #1 cyc++; end
    expected = 8'h00;
    st[0] = 1'b1;
    @(posedge clk); #1 cyc++;
    st[0] = 1'b0;
    wait_done(0, cyc);
    chk("t4_cycles", cyc, 24);
    chk("t4_pass", ps[0], 1);
    expected = 8'hE8;
    run(0, cyc);
    chk("t4_restart_cycles", cyc, 24);
    chk("t4_restart_pass", ps[0], 1);

    // T5: reset mid-run
    pulse(0);
    repeat (12) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_busy", bz[0], 0);
    chk("t5_dut_in", in0, 0);
    chk("t5_err", err0, 0);
    chk("t5_done", dn[0], 0);
    @(negedge clk) rst_n = 1'b1;
    cyc = 0;
    wait_done(0, cyc);
    chk("t5_no_done", dn[0], 0);
    run(0, cyc);
    chk("t5_resweep_cycles", cyc, 24);
    chk("t5_resweep_pass", ps[0], 1);

    // T6: latency-2 mock fails with SETTLE=1, passes with SETTLE=2
    run(2, cyc);
    chk("t6_s1_cycles", cyc, 16);
    chk("t6_s1_err", err2, 3);
    chk("t6_s1_ffvec", ffv_vec2, 3);
    chk("t6_s1_pass", ps[2], 0);
    m0 = 3;
    run(0, cyc);
    chk("t6_s2_err", err0, 0);
    chk("t6_s2_pass", ps[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
